bram_dual_param: RTL and testbench
==================================

Name: bram_dual_param

Overview:
- Parametrised, single-clock, true dual-port block RAM. It is the next generation of the team's fixed 16x512 dual-port BRAM.
- Adds:
  - configurable width and depth
  - per-byte write enables
  - selectable read-during-write mode
  - optional output pipeline register with read-valid strobes
  - deterministic same-address write arbitration with a collision flag
  - a post-reset clear sequencer that zeroes the array
- Used as shared scratch storage between two datapath engines in the same clock domain.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_BITS, 9, address width; DEPTH = 2**ADDR_BITS words.
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
- OUT_REG, 0, 1 = extra output register stage (read latency 2), 0 = latency 1.
- RDW_MODE, 0, same-port read-during-write behaviour: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- INIT_CLEAR, 1, 1 = zero the whole array after every reset; 0 = no clear.

Ports:
- clk  in  1  single clock for both ports.
- rst  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the clear sequencer runs; port accesses are ignored.
- collision  out  1  one-cycle pulse: both ports wrote the same address in the same cycle.
- en_a  in  1  port A access enable.
- we_a  in  NB  port A byte write enables; 0 = read.
- addr_a  in  ADDR_BITS  port A address.
- data_in_a  in  DATA_WIDTH  port A write data.
- data_out_a  out  DATA_WIDTH  port A read data.
- valid_a  out  1  port A read data valid strobe.
- en_b, we_b, addr_b, data_in_b, data_out_b, valid_b: same widths and meanings for port B.

Behaviour:
- Reset, applied while rst is high at a clk edge:
  - data_out_a/b = 0 and valid_a/b = 0, including both pipeline stages when OUT_REG=1.
  - collision = 0; clear counter = 0.
  - init_busy = INIT_CLEAR. Array contents are otherwise untouched by rst.
- Clear FSM, states IDLE and CLEAR:
  - On the first cycle with rst low and INIT_CLEAR=1, the FSM is in CLEAR.
  - In CLEAR, each cycle writes 0 to address cnt, then cnt increments.
  - After writing DEPTH-1: go to IDLE; init_busy drops on the next edge. Total busy time is DEPTH cycles after rst deasserts.
  - rst asserted mid-clear restarts the clear from address 0.
  - INIT_CLEAR=0: the FSM is held in IDLE.
- Accepted access: en_x=1 and init_busy=0. While busy, en/we are ignored: no write, no valid, data_out holds.
- Writes: each byte lane i with we_x[i]=1 is written with data_in_x[i]; other lanes are preserved.
- Read latency: 1+OUT_REG cycles from the accepting edge to data_out_x/valid_x.
  - valid_x is a one-cycle pulse per read-producing access.
  - data_out_x holds its last value when there is no new read.
- Read-producing access: we_x=0, or we_x!=0 with RDW_MODE 0 or 1.
  - READ_FIRST: returns the old word.
  - WRITE_FIRST: returns the merged word (new bytes in enabled lanes, old bytes elsewhere).
  - NO_CHANGE: a write produces no valid and leaves data_out unchanged.
- Cross-port, same address, same cycle:
  - A read on one port returns the old word regardless of RDW_MODE.
  - Both ports writing: lanes enabled on both take port A data; lanes enabled only on B take B data.
  - collision pulses one cycle later when both accesses are accepted, both we are nonzero and addresses are equal, regardless of lane overlap.
- Different addresses: the ports are fully independent, one access per port per cycle.

Test Plan:
- Reset then clear, DEPTH=512, INIT_CLEAR=1:
  - init_busy stays high exactly 512 cycles after rst falls.
  - Afterwards, reads of addresses 0, 255 and 511 return 0x0000 with valid one cycle later.
- Access during busy: port A write of 0xBEEF to address 7 at clear cycle 3 -> after clear, a read of address 7 returns 0x0000 and no valid pulses during busy.
- Byte enables, port A:
  - Write 0x1234 to address 5 with we=2'b11, then 0xAB00 with we=2'b10.
  - Port B read of address 5 -> 0xAB34.
- Read-during-write, address 9 holding 0x1111, port A writes 0x2222 with we=2'b11:
  - RDW_MODE=0 -> data_out_a=0x1111, valid_a=1.
  - RDW_MODE=1 -> data_out_a=0x2222, valid_a=1.
  - RDW_MODE=2 -> valid_a=0, data_out unchanged.
- Collision, same cycle at address 3: A writes 0xAAAA with we=2'b01, B writes 0x5555 with we=2'b11 -> collision=1 for one cycle, then a read of address 3 returns 0x55AA.
- OUT_REG=1 with back-to-back reads of addresses 1, 2, 3 (pre-loaded with 0x0001, 0x0002, 0x0003) -> valid_a high for 3 consecutive cycles starting 2 cycles after the first request; rst mid-stream clears valid_a and data_out_a to 0 on the next edge.

Source files
------------

// File: rtl/bram_dual_param.sv
// Parametrised single-clock true dual-port RAM with byte enables,
// read-during-write modes, optional output register and post-reset clear.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   init_busy                clear sequencer running, port accesses ignored
//   collision                pulse: both ports wrote one address last cycle
//   en_x, we_x, addr_x       port x enable, byte write enables, address
//   data_in_x                port x write data
//   data_out_x, valid_x      port x read data and read-valid strobe
module bram_dual_param #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 9,
  parameter int BYTE_WIDTH = 8,
  parameter int OUT_REG    = 0,
  parameter int RDW_MODE   = 0,
  parameter int INIT_CLEAR = 1,
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH,
  localparam int DEPTH = 2 ** ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic                  collision,
  input  logic                  en_a,
  input  logic [NB-1:0]         we_a,
  input  logic [ADDR_BITS-1:0]  addr_a,
  input  logic [DATA_WIDTH-1:0] data_in_a,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic                  valid_a,
  input  logic                  en_b,
  input  logic [NB-1:0]         we_b,
  input  logic [ADDR_BITS-1:0]  addr_b,
  input  logic [DATA_WIDTH-1:0] data_in_b,
  output logic [DATA_WIDTH-1:0] data_out_b,
  output logic                  valid_b
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] cnt, cnt_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Index 0 is port A, index 1 is port B.
  logic [1:0]                 en, acc, wr, vld;
  logic [1:0][NB-1:0]         we;
  logic [1:0][ADDR_BITS-1:0]  addr;
  logic [1:0][DATA_WIDTH-1:0] din, dout;

  assign en   = {en_b, en_a};
  assign we   = {we_b, we_a};
  assign addr = {addr_b, addr_a};
  assign din  = {data_in_b, data_in_a};

  assign data_out_a = dout[0];
  assign data_out_b = dout[1];
  assign valid_a    = vld[0];
  assign valid_b    = vld[1];

  assign init_busy = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: ;
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == {ADDR_BITS{1'b1}})
          state_nxt = IDLE;
      end
      default: ;
    endcase
  end

  assign acc = en & {2{~init_busy & ~rst}};
  assign wr  = {acc[1] & (|we[1]), acc[0] & (|we[0])};

  // Port B is applied first so lanes enabled on both ports end up with A.
  always_ff @(posedge clk) begin
    if (init_busy && !rst) begin
      mem[cnt] <= '0;
    end else begin
      for (int p = 1; p >= 0; p--) begin
        for (int i = 0; i < NB; i++) begin
          if (acc[p] && we[p][i])
            mem[addr[p]][i*BYTE_WIDTH +: BYTE_WIDTH] <=
              din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      collision <= 1'b0;
    else
      collision <= wr[0] & wr[1] & (addr[0] == addr[1]);
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_WIDTH-1:0] old, merged, rdata, d1;
    logic                  rd, v1;

    // Array read sees pre-write contents, so cross-port reads get old data.
    assign old = mem[addr[p]];

    always_comb begin
      merged = old;
      for (int i = 0; i < NB; i++) begin
        if (we[p][i])
          merged[i*BYTE_WIDTH +: BYTE_WIDTH] =
            din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end

    assign rd    = acc[p] & ((we[p] == '0) | (RDW_MODE != 2));
    assign rdata = (RDW_MODE == 1) ? merged : old;

    always_ff @(posedge clk) begin
      if (rst) begin
        v1 <= 1'b0;
        d1 <= '0;
      end else begin
        v1 <= rd;
        if (rd)
          d1 <= rdata;
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] d2;
      logic                  v2;

      always_ff @(posedge clk) begin
        if (rst) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1)
            d2 <= d1;
        end
      end

      assign dout[p] = d2;
      assign vld[p]  = v2;
    end else begin : g_noreg
      assign dout[p] = d1;
      assign vld[p]  = v1;
    end
  end

endmodule

// File: tb/tb_bram_dual_param.sv
// Bench for bram_dual_param: four configurations share one stimulus
// and are compared every cycle against a word-level reference model.
module tb_bram_dual_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  en;
  logic [1:0]  we   [2];
  logic [8:0]  addr [2];
  logic [15:0] din  [2];

  logic [3:0]  busy, coll, va, vb;
  logic [15:0] da [4];
  logic [15:0] db [4];

  int passes = 0;
  int total  = 0;

  // Instance k: RDW_MODE = k%3, OUT_REG = (k>=2).
  for (genvar k = 0; k < 4; k++) begin : g_dut
    bram_dual_param #(
      .OUT_REG  ((k >= 2) ? 1 : 0),
      .RDW_MODE (k % 3)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .init_busy  (busy[k]),
      .collision  (coll[k]),
      .en_a       (en[0]),
      .we_a       (we[0]),
      .addr_a     (addr[0]),
      .data_in_a  (din[0]),
      .data_out_a (da[k]),
      .valid_a    (va[k]),
      .en_b       (en[1]),
      .we_b       (we[1]),
      .addr_b     (addr[1]),
      .data_in_b  (din[1]),
      .data_out_b (db[k]),
      .valid_b    (vb[k])
    );
  end

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s[u%0d]: got %0h want %0h", nm, k, act, exp);
  endtask

  function automatic logic [15:0] merge(input logic [15:0] o,
                                        input logic [1:0] w,
                                        input logic [15:0] d);
    logic [15:0] r;
    r = o;
    if (w[0]) r[7:0]  = d[7:0];
    if (w[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // Reference model: word array, clear countdown, per-config delay line.
  logic [15:0] mmem [512];
  int          clr_left;
  bit          seen_rst = 1'b0;
  bit          e_busy, e_coll, pb, rv;
  bit          acc [2];
  logic [15:0] oldw [2];
  logic [15:0] rdv;
  bit          s1v [4][2];
  bit          ev  [4][2];
  logic [15:0] s1d [4][2];
  logic [15:0] ed  [4][2];

  always @(posedge clk) begin
    if (rst) begin
      seen_rst = 1'b1;
      clr_left = 512;
      e_busy   = 1'b1;
      e_coll   = 1'b0;
      for (int k = 0; k < 4; k++)
        for (int p = 0; p < 2; p++) begin
          s1v[k][p] = 1'b0;
          ev[k][p]  = 1'b0;
          s1d[k][p] = '0;
          ed[k][p]  = '0;
        end
    end else if (seen_rst) begin
      pb = clr_left > 0;
      for (int p = 0; p < 2; p++) begin
        acc[p]  = en[p] && !pb;
        oldw[p] = mmem[addr[p]];
      end
      for (int k = 0; k < 4; k++)
        for (int p = 0; p < 2; p++) begin
          rv  = acc[p] && (we[p] == 0 || k % 3 != 2);
          rdv = (k % 3 == 1) ? merge(oldw[p], we[p], din[p]) : oldw[p];
          if (k >= 2) begin
            ev[k][p] = s1v[k][p];
            if (s1v[k][p]) ed[k][p] = s1d[k][p];
            s1v[k][p] = rv;
            if (rv) s1d[k][p] = rdv;
          end else begin
            ev[k][p] = rv;
            if (rv) ed[k][p] = rdv;
          end
        end
      e_coll = acc[0] && acc[1] && we[0] != 0 && we[1] != 0 &&
               addr[0] == addr[1];
      if (pb) begin
        mmem[512 - clr_left] = '0;
        clr_left--;
      end else begin
        for (int p = 1; p >= 0; p--)
          if (acc[p]) mmem[addr[p]] = merge(mmem[addr[p]], we[p], din[p]);
      end
      e_busy = clr_left > 0;
    end
  end

  always @(negedge clk) begin
    if (seen_rst) begin
      for (int k = 0; k < 4; k++) begin
        chk("busy", k, 32'(busy[k]), 32'(e_busy));
        chk("collision", k, 32'(coll[k]), 32'(e_coll));
        chk("valid_a", k, 32'(va[k]), 32'(ev[k][0]));
        chk("data_a", k, 32'(da[k]), 32'(ed[k][0]));
        chk("valid_b", k, 32'(vb[k]), 32'(ev[k][1]));
        chk("data_b", k, 32'(db[k]), 32'(ed[k][1]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_a(input bit e, input int w, input int a, input int d);
    en[0] = e; we[0] = 2'(w); addr[0] = 9'(a); din[0] = 16'(d);
  endtask

  task automatic set_b(input bit e, input int w, input int a, input int d);
    en[1] = e; we[1] = 2'(w); addr[1] = 9'(a); din[1] = 16'(d);
  endtask

  task automatic idle();
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
  endtask

  // Counts busy cycles, pokes a write at clear cycle 3, reads throughout.
  task automatic clear_wait(output int n, output int nv);
    n  = 0;
    nv = 0;
    while (busy[0] && n < 2000) begin
      n++;
      if (n == 4) set_a(1, 3, 7, 16'hBEEF);
      else        set_a(0, 0, 0, 0);
      set_b(1, 0, 7, 0);
      tick();
      nv += int'(va != 0) + int'(vb != 0);
    end
    idle();
  endtask

  int          n, nv;
  logic [15:0] prev2;

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) tick();
    chk("rst busy", 0, 32'(busy[0]), 32'd1);
    chk("rst data_a", 3, 32'(da[3]), 32'd0);
    chk("rst valid_a", 3, 32'(va[3]), 32'd0);
    chk("rst collision", 0, 32'(coll[0]), 32'd0);

    rst = 1'b0;
    clear_wait(n, nv);
    chk("busy cycles", 0, 32'(n), 32'd512);
    chk("valid while busy", 0, 32'(nv), 32'd0);

    set_a(1, 0, 0, 0); set_b(1, 0, 7, 0); tick();
    chk("read 0 data", 0, 32'(da[0]), 32'h0);
    chk("read 0 valid", 0, 32'(va[0]), 32'd1);
    chk("read 7 data", 0, 32'(db[0]), 32'h0);
    chk("read 7 valid", 0, 32'(vb[0]), 32'd1);
    set_a(1, 0, 255, 0); set_b(0, 0, 0, 0); tick();
    chk("read 255 valid", 0, 32'(va[0]), 32'd1);
    set_a(1, 0, 511, 0); tick();
    chk("read 511 data", 0, 32'(da[0]), 32'h0);

    set_a(1, 3, 5, 16'h1234); tick();
    set_a(1, 2, 5, 16'hAB00); tick();
    set_a(0, 0, 0, 0); set_b(1, 0, 5, 0); tick();
    chk("byte enable", 0, 32'(db[0]), 32'hAB34);
    chk("byte enable valid", 0, 32'(vb[0]), 32'd1);

    set_b(0, 0, 0, 0);
    set_a(1, 3, 9, 16'h1111); tick();
    prev2 = da[2];
    set_a(1, 3, 9, 16'h2222); tick();
    chk("read first", 0, 32'(da[0]), 32'h1111);
    chk("read first valid", 0, 32'(va[0]), 32'd1);
    chk("write first", 1, 32'(da[1]), 32'h2222);
    chk("write first valid", 1, 32'(va[1]), 32'd1);
    idle(); tick();
    chk("no change valid", 2, 32'(va[2]), 32'd0);
    chk("no change data", 2, 32'(da[2]), 32'(prev2));
    chk("oreg read first", 3, 32'(da[3]), 32'h1111);

    set_a(1, 1, 3, 16'hAAAA); set_b(1, 3, 3, 16'h5555); tick();
    chk("collision pulse", 0, 32'(coll[0]), 32'd1);
    set_a(1, 0, 3, 0); set_b(0, 0, 0, 0); tick();
    chk("collision end", 0, 32'(coll[0]), 32'd0);
    chk("collision merge", 0, 32'(da[0]), 32'h55AA);

    set_a(1, 3, 1, 1); tick();
    set_a(1, 3, 2, 2); tick();
    set_a(1, 3, 3, 3); tick();
    idle(); tick(); tick();
    set_a(1, 0, 1, 0); tick();
    chk("oreg lat1 valid", 3, 32'(va[3]), 32'd0);
    set_a(1, 0, 2, 0); tick();
    chk("oreg first valid", 3, 32'(va[3]), 32'd1);
    chk("oreg first data", 3, 32'(da[3]), 32'h1);
    set_a(1, 0, 3, 0); tick();
    chk("oreg second data", 3, 32'(da[3]), 32'h2);
    set_a(1, 0, 1, 0); tick();
    chk("oreg third valid", 3, 32'(va[3]), 32'd1);
    chk("oreg third data", 3, 32'(da[3]), 32'h3);
    set_a(1, 0, 2, 0); rst = 1'b1; tick();
    chk("rst mid valid", 3, 32'(va[3]), 32'd0);
    chk("rst mid data", 3, 32'(da[3]), 32'd0);

    idle(); tick();
    rst = 1'b0;
    repeat (100) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    clear_wait(n, nv);
    chk("restart busy cycles", 0, 32'(n), 32'd512);
    set_a(1, 0, 3, 0); tick();
    chk("cleared again", 0, 32'(da[0]), 32'h0);

    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        en[p]   = $urandom_range(0, 3) != 0;
        we[p]   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
        addr[p] = 9'($urandom_range(0, 15));
        din[p]  = 16'($urandom);
      end
      rst = $urandom_range(0, 999) == 0;
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
